// File: rtl/det_load_sequencer.sv
// det_load_sequencer: loads a row-major element stream into a flat matrix, starts the 5x5 determinant engine, and holds its result.
// Optional WAIT-state watchdog: define DET_TIMEOUT_EN (limit TIMEOUT_CYCLES).
`default_nettype none

module det_load_sequencer #(
  parameter int ELEM_W         = 8,
  parameter int DIM            = 5,
  parameter int DET_W          = 40,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ELEM_W-1:0]         in_data,
  input  logic                      in_last,
  output logic                      det_start,
  output logic [DIM*DIM*ELEM_W-1:0] det_matrix,
  input  logic                      det_done,
  input  logic [DET_W-1:0]          det_result,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DET_W-1:0]          out_det,
  output logic                      out_err,
  output logic                      busy
);

  localparam int NELEM = DIM * DIM;
  localparam int CW    = (NELEM > 1) ? $clog2(NELEM) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NELEM - 1);

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [CW-1:0]           count_q, count_d;
  logic [NELEM*ELEM_W-1:0] matrix_q, matrix_d;
  logic [DET_W-1:0]        det_q, det_d;
  logic                    err_q, err_d;
  logic                    beat;
  logic                    timeout;

`ifdef DET_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] wdog_q, wdog_d;

  // Held at zero outside WAIT, so every WAIT entry starts a fresh count.
  always_comb begin
    wdog_d = '0;
    if (state_q == S_WAIT && !timeout) wdog_d = wdog_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) wdog_q <= '0;
    else       wdog_q <= wdog_d;
  end

  assign timeout = (state_q == S_WAIT) && (wdog_q == WD_LAST);
`else
  assign timeout = 1'b0;
`endif

  // Gated by reset so the port reads 0 for the whole time reset is held.
  assign in_ready = (state_q == S_LOAD) && !reset;
  assign beat     = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    matrix_d = matrix_q;
    det_d    = det_q;
    err_d    = err_q;
    case (state_q)
      S_LOAD: begin
        if (beat) begin
          matrix_d[count_q*ELEM_W +: ELEM_W] = in_data;
          if (count_q == LAST_IDX) begin
            state_d = S_START;
            count_d = '0;
          end else if (in_last) begin
            state_d = S_HOLD;
            det_d   = '0;
            err_d   = 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (det_done) begin
          state_d = S_HOLD;
          det_d   = det_result;
          err_d   = 1'b0;
        end else if (timeout) begin
          state_d = S_HOLD;
          det_d   = '0;
          err_d   = 1'b1;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_LOAD;
          count_d = '0;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_LOAD;
      count_q  <= '0;
      matrix_q <= '0;
      det_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      matrix_q <= matrix_d;
      det_q    <= det_d;
      err_q    <= err_d;
    end
  end

  assign det_start  = (state_q == S_START);
  assign out_valid  = (state_q == S_HOLD);
  assign det_matrix = matrix_q;
  assign out_det    = det_q;
  assign out_err    = err_q;
  assign busy       = !((state_q == S_LOAD) && (count_q == '0));

endmodule

`default_nettype wire

// File: tb/tb_det_load_sequencer.sv
// Bench for det_load_sequencer: randomized host/engine/consumer traffic against a frame-level model.
`timescale 1ns/1ps
`default_nettype none

module tb_det_load_sequencer;

  localparam int ELEM_W = 8;
  localparam int DIM    = 5;
  localparam int DET_W  = 40;
  localparam int TMO    = 16;
  localparam int N      = DIM * DIM;

  localparam int P_LOAD  = 0;
  localparam int P_START = 1;
  localparam int P_WAIT  = 2;
  localparam int P_HOLD  = 3;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [ELEM_W-1:0]     in_data = '0;
  logic                  in_last = 1'b0;
  logic                  det_start;
  logic [N*ELEM_W-1:0]   det_matrix;
  logic                  det_done = 1'b0;
  logic [DET_W-1:0]      det_result = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [DET_W-1:0]      out_det;
  logic                  out_err;
  logic                  busy;

  det_load_sequencer #(
    .ELEM_W(ELEM_W), .DIM(DIM), .DET_W(DET_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .det_start(det_start), .det_matrix(det_matrix),
    .det_done(det_done), .det_result(det_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_det(out_det), .out_err(out_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // frame-level model
  int               ph = P_LOAD;
  int               m_cnt = 0;
  logic [7:0]       m_mat [N];
  logic [DET_W-1:0] m_det = '0;
  logic             m_err = 1'b0;
  logic [DET_W-1:0] m_frame_det = '0;
  int               m_wd = 0;

  // host / consumer / engine knobs
  logic [8:0]       tx_q [$];
  logic [7:0]       fr [N];
  int               gap_pct = 0;
  int               stall = 0;
  int               hold_cnt = 0;
  int               eng_wait = -1;
  int               eng_lo = 0;
  int               eng_hi = 6;
  bit               eng_level = 1'b0;
  bit               eng_dead = 1'b0;
  logic [DET_W-1:0] eng_val = '0;

  // observations
  int               starts = 0;
  int               hs = 0;
  int               start_cyc = 0;
  int               valid_cyc = 0;
  bit               prev_valid = 1'b0;
  logic [DET_W-1:0] last_det;
  logic             last_err;
  logic [N*ELEM_W-1:0] last_mat;
  int               last_hold = 0;

  function automatic longint det5(input logic [N*ELEM_W-1:0] mat);
    longint a [DIM][DIM];
    longint prev, t;
    int     sgn, p;
    prev = 1;
    sgn  = 1;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        a[r][c] = longint'(mat[(r*DIM+c)*ELEM_W +: ELEM_W]);
    for (int k = 0; k < DIM-1; k++) begin
      if (a[k][k] == 0) begin
        p = -1;
        for (int r = k+1; r < DIM; r++) if (p < 0 && a[r][k] != 0) p = r;
        if (p < 0) return 0;
        for (int c = 0; c < DIM; c++) begin
          t = a[k][c]; a[k][c] = a[p][c]; a[p][c] = t;
        end
        sgn = -sgn;
      end
      for (int i = k+1; i < DIM; i++)
        for (int j = k+1; j < DIM; j++)
          a[i][j] = (a[i][j]*a[k][k] - a[i][k]*a[k][j]) / prev;
      prev = a[k][k];
    end
    return sgn * a[DIM-1][DIM-1];
  endfunction

  function automatic logic [N*ELEM_W-1:0] pack_model();
    logic [N*ELEM_W-1:0] v;
    for (int i = 0; i < N; i++) v[i*ELEM_W +: ELEM_W] = m_mat[i];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    ph = P_LOAD; m_cnt = 0; m_det = '0; m_err = 1'b0; m_wd = 0;
    for (int i = 0; i < N; i++) m_mat[i] = '0;
  endtask

  // One cycle: compare at negedge, then drive the next inputs and advance the model.
  task automatic tick(input bit rst_nx);
    logic [8:0] head;
    @(negedge clk);
    cyc++;
    chk("in_ready",   in_ready,   (ph == P_LOAD) && !reset);
    chk("det_start",  det_start,  ph == P_START);
    chk("out_valid",  out_valid,  ph == P_HOLD);
    chk("busy",       busy,       !(ph == P_LOAD && m_cnt == 0));
    chk("det_matrix", det_matrix, pack_model());
    chk("out_det",    out_det,    m_det);
    chk("out_err",    out_err,    m_err);
    if (det_start) begin
      starts++;
      start_cyc = cyc;
      eng_val = DET_W'(det5(det_matrix));
    end
    if (out_valid && !prev_valid) valid_cyc = cyc;
    prev_valid = out_valid;

    reset = rst_nx;
    if (tx_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
      head = tx_q[0];
      in_valid = 1'b1; in_data = head[7:0]; in_last = head[8];
    end else begin
      in_valid = 1'b0; in_data = 8'($urandom); in_last = 1'($urandom);
    end
    if (ph == P_HOLD) begin
      hold_cnt++;
      out_ready = (hold_cnt > stall) && ($urandom_range(2) != 0);
    end else begin
      hold_cnt = 0;
      out_ready = 1'($urandom);
    end
    if (rst_nx) begin
      det_done = 1'b0; eng_wait = -1;
    end else if (det_start) begin
      det_result = eng_val;
      eng_level = 1'($urandom);
      eng_wait = eng_dead ? -1 : int'($urandom_range(eng_hi, eng_lo));
    end else if (eng_dead) begin
      det_done = 1'b0;
    end else if (eng_wait > 0) begin
      det_done = 1'b0; eng_wait--;
    end else if (eng_wait == 0) begin
      det_done = 1'b1; eng_wait = -1;
    end else if (!eng_level) begin
      det_done = 1'b0;
    end
    if (!rst_nx && out_valid && out_ready) begin
      hs++; last_det = out_det; last_err = out_err; last_mat = det_matrix; last_hold = hold_cnt;
    end

    if (rst_nx) model_reset();
    else begin
      case (ph)
        P_LOAD: if (in_valid) begin
          void'(tx_q.pop_front());
          m_mat[m_cnt] = in_data;
          if (m_cnt == N-1) begin
            ph = P_START; m_cnt = 0; m_frame_det = DET_W'(det5(pack_model()));
          end else if (in_last) begin
            ph = P_HOLD; m_det = '0; m_err = 1'b1;
          end else m_cnt++;
        end
        P_START: begin ph = P_WAIT; m_wd = 0; end
        P_WAIT: begin
          if (det_done) begin
            ph = P_HOLD; m_det = m_frame_det; m_err = 1'b0;
          end else begin
            m_wd++;
`ifdef DET_TIMEOUT_EN
            if (m_wd == TMO) begin ph = P_HOLD; m_det = '0; m_err = 1'b1; end
`endif
          end
        end
        default: if (out_ready) begin ph = P_LOAD; m_cnt = 0; end
      endcase
    end
  endtask

  task automatic push_frame(input int len, input int last_at);
    for (int i = 0; i < len; i++) tx_q.push_back({(i == last_at), fr[i]});
  endtask

  task automatic run_until(input int target, input int budget, input string nm);
    int n = 0;
    while (hs < target && n < budget) begin tick(1'b0); n++; end
    n_cmp++;
    if (hs < target) begin
      n_fail++;
      $display("FAIL %s: timed out, handshakes %0d required %0d", nm, hs, target);
    end
  endtask

  task automatic set_diag(input logic [7:0] d);
    for (int i = 0; i < N; i++) fr[i] = (i % (DIM+1) == 0) ? d : 8'd0;
  endtask

  initial begin
    int s0, h0, n, len;
    model_reset();
    repeat (2) @(posedge clk);
    tick(1'b1); tick(1'b1);
    chk("rst_in_ready", in_ready, 0);  chk("rst_det_start", det_start, 0);
    chk("rst_out_valid", out_valid, 0); chk("rst_busy", busy, 0);
    chk("rst_matrix", det_matrix, 0);  chk("rst_out_det", out_det, 0);
    chk("rst_out_err", out_err, 0);
    tick(1'b0);
    #1 chk("rel_in_ready", in_ready, 1);

    // case 1: 1..25 row-major
    for (int i = 0; i < N; i++) fr[i] = 8'(i + 1);
    s0 = starts; h0 = hs;
    push_frame(N, N-1);
    run_until(h0+1, 400, "t1_wait");
    chk("t1_m0", last_mat[7:0], 1);  chk("t1_m24", last_mat[199:192], 25);
    chk("t1_det", last_det, 0);      chk("t1_err", last_err, 0);
    chk("t1_starts", starts - s0, 1);

    // case 2: diagonal 2, in_last left low on the 25th beat
    set_diag(8'd2); h0 = hs;
    push_frame(N, -1);
    run_until(h0+1, 400, "t2_wait");
    chk("t2_det", last_det, 32); chk("t2_err", last_err, 0);

    // case 3: gaps and a 10-cycle consumer stall
    set_diag(8'd3); h0 = hs; gap_pct = 40; stall = 10;
    push_frame(N, N-1);
    run_until(h0+1, 600, "t3_wait");
    chk("t3_det", last_det, 243); chk("t3_hold_ge11", last_hold >= 11, 1);
    stall = 0;

    // case 4: early in_last on the 10th beat
    for (int i = 0; i < N; i++) fr[i] = 8'($urandom);
    s0 = starts; h0 = hs;
    push_frame(10, 9);
    run_until(h0+1, 400, "t4_wait");
    chk("t4_err", last_err, 1); chk("t4_det", last_det, 0); chk("t4_starts", starts - s0, 0);

    // random frames, queued in pairs so in_valid stays up while busy
    for (int f = 0; f < 8; f++) begin
      h0 = hs; gap_pct = $urandom_range(60); stall = $urandom_range(3);
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < N; i++) fr[i] = 8'($urandom_range(31));
        len = ($urandom_range(3) == 0) ? int'($urandom_range(N-1, 1)) : N;
        push_frame(len, (len < N) ? len-1 : (($urandom_range(1) == 1) ? N-1 : -1));
      end
      run_until(h0+2, 1500, "rnd_wait");
    end
    stall = 0; gap_pct = 0;

    // case 5: reset while the engine is still working
    set_diag(8'd2); eng_lo = 20; eng_hi = 25;
    push_frame(N, N-1);
    n = 0;
    while (ph != P_WAIT && n < 300) begin tick(1'b0); n++; end
    tick(1'b0); tick(1'b0);
    tick(1'b1);
    tx_q.delete();
    tick(1'b0);
    #1;
    chk("t5_in_ready", in_ready, 1);  chk("t5_det_start", det_start, 0);
    chk("t5_out_valid", out_valid, 0); chk("t5_busy", busy, 0);
    chk("t5_matrix", det_matrix, 0);  chk("t5_out_det", out_det, 0);
    chk("t5_out_err", out_err, 0);
    eng_lo = 0; eng_hi = 6; h0 = hs;
    push_frame(N, N-1);
    run_until(h0+1, 400, "t5_wait");
    chk("t5_det", last_det, 32);

`ifdef DET_TIMEOUT_EN
    // case 6: engine never answers
    eng_dead = 1'b1; h0 = hs;
    push_frame(N, N-1);
    run_until(h0+1, 400, "t6_wait");
    chk("t6_err", last_err, 1); chk("t6_det", last_det, 0);
    chk("t6_wait_len", valid_cyc - start_cyc, TMO + 1);
    eng_dead = 1'b0;
`endif

    repeat (3) tick(1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
